// File: rtl/max31855_pkg.sv
// -----------------------------------------------------------------------------
// max31855_pkg
// Shared constants, the FSM state type and the frame-assembly helper for the
// MAX31855 thermocouple-converter responder.
// -----------------------------------------------------------------------------
package max31855_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned TC_W       = 14;
  localparam int unsigned CJ_W       = 12;
  localparam int unsigned FLT_W      = 3;
  localparam int unsigned BIT_CNT_W  = 5;

  // Frame field positions
  localparam int unsigned TC_MSB     = 31;
  localparam int unsigned TC_LSB     = 18;
  localparam int unsigned RSVD_HI    = 17;
  localparam int unsigned FAULT_BIT  = 16;
  localparam int unsigned CJ_MSB     = 15;
  localparam int unsigned CJ_LSB     = 4;
  localparam int unsigned RSVD_LO    = 3;
  localparam int unsigned FLT_MSB    = 2;
  localparam int unsigned FLT_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Assemble the 32-bit read frame; reserved bits are always 0.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [TC_W-1:0]  tc,
    input logic [CJ_W-1:0]  cj,
    input logic [FLT_W-1:0] flt
  );
    logic [FRAME_BITS-1:0] f;
    f                  = '0;
    f[TC_MSB:TC_LSB]   = tc;
    f[RSVD_HI]         = 1'b0;
    f[FAULT_BIT]       = |flt;
    f[CJ_MSB:CJ_LSB]   = cj;
    f[RSVD_LO]         = 1'b0;
    f[FLT_MSB:FLT_LSB] = flt;
    return f;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Synchronises one asynchronous input through SYNC_STAGES flops and reports
// the synchronised level plus single-cycle rise/fall pulses.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   async_i      asynchronous input pin
//   level_o      synchronised level (last synchroniser flop)
//   rise_c_o     combinational pulse, synchronised 0->1 transition
//   fall_c_o     combinational pulse, synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o  = sync_q[SYNC_STAGES-1];
  assign rise_c_o =  level_o & ~prev_q;
  assign fall_c_o = ~level_o &  prev_q;

endmodule

// File: rtl/max31855_responder.sv
// -----------------------------------------------------------------------------
// max31855_responder
// Emulates the SPI read side of a MAX31855 thermocouple converter. While
// SPI_cs is high a conversion timer runs; each completed period latches the
// current temperature inputs into a 32-bit frame which is shifted out MSB
// first on SPI_Data_Out, changing on SPI_clk falling edges.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   SPI_clk       master serial clock (asynchronous)
//   SPI_cs        master chip select, active low (asynchronous)
//   SPI_Data_Out  serial data to master
//   tc_temp       thermocouple temperature, 14-bit signed
//   int_temp      cold-junction temperature, 12-bit signed
//   fault_in      {SCV, SCG, OC}
//   conv_valid    set once the first conversion has completed
//   frame_done    one-cycle pulse after bit 0 has been shifted out
// Build option: MAX31855_FAULT_INJECT_EN routes fault_in into the frame;
// without it the fault bits read 0.
// -----------------------------------------------------------------------------
module max31855_responder
  import max31855_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 10_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SPI_clk,
  input  logic             SPI_cs,
  output logic             SPI_Data_Out,
  input  logic [TC_W-1:0]  tc_temp,
  input  logic [CJ_W-1:0]  int_temp,
  input  logic [FLT_W-1:0] fault_in,
  output logic             conv_valid,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_TOP = BIT_CNT_W'(FRAME_BITS - 1);

  // Synchronised SPI pins
  logic cs_level, cs_rise, cs_fall;
  logic sclk_fall;
  logic sclk_level_unused, sclk_rise_unused;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_i  (SPI_clk),
    .level_o  (sclk_level_unused),
    .rise_c_o (sclk_rise_unused),
    .fall_c_o (sclk_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_i  (SPI_cs),
    .level_o  (cs_level),
    .rise_c_o (cs_rise),
    .fall_c_o (cs_fall)
  );

  // Fault field source
  logic [FLT_W-1:0] fault_c;
`ifdef MAX31855_FAULT_INJECT_EN
  assign fault_c = fault_in;
`else
  logic unused_fault_c;
  assign fault_c        = '0;
  assign unused_fault_c = ^fault_in;
`endif

  logic [FRAME_BITS-1:0] frame_c;
  assign frame_c = build_frame(tc_temp, int_temp, fault_c);

  // Conversion timer: only a full uninterrupted high period of SPI_cs
  // produces a new frame; a falling chip select discards the partial count.
  logic [CNT_W-1:0]      conv_cnt_q;
  logic [FRAME_BITS-1:0] conv_q;
  logic                  conv_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_cnt_q   <= '0;
      conv_q       <= '0;
      conv_valid_q <= 1'b0;
    end else if (!cs_level) begin
      conv_cnt_q   <= '0;
    end else if (conv_cnt_q == CNT_LAST) begin
      conv_cnt_q   <= '0;
      conv_q       <= frame_c;
      conv_valid_q <= 1'b1;
    end else begin
      conv_cnt_q   <= conv_cnt_q + CNT_W'(1);
    end
  end

  // Read FSM
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  dout_q, dout_d;
  logic                  frame_done_q, frame_done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= BIT_CNT_TOP;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic; chip-select release wins from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (sclk_fall && (bit_cnt_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // Output/datapath logic; bit 31 is presented in the load cycle so the
  // master can sample it before the first SPI_clk edge.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          shift_d   = conv_q;
          bit_cnt_d = BIT_CNT_TOP;
          dout_d    = conv_q[FRAME_BITS-1];
        end
      end
      ST_SHIFT: begin
        if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            dout_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            dout_d    = shift_q[FRAME_BITS-2];
          end
        end
      end
      ST_DONE: dout_d = 1'b0;
      default: dout_d = 1'b0;
    endcase
    if (cs_rise) dout_d = 1'b0;
  end

  assign SPI_Data_Out = dout_q;
  assign conv_valid   = conv_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_max31855_responder.sv
// -----------------------------------------------------------------------------
// tb_max31855_responder
// Self-checking bench: an SPI master reads frames while a reference model
// tracks which temperature/fault inputs the last full conversion captured.
// -----------------------------------------------------------------------------
module tb_max31855_responder;

  localparam int unsigned CONV = 200;  // conversion period in clk cycles
  localparam int unsigned H    = 6;    // SPI_clk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        SPI_clk;
  logic        SPI_cs;
  logic        SPI_Data_Out;
  logic [13:0] tc_temp;
  logic [11:0] int_temp;
  logic [2:0]  fault_in;
  logic        conv_valid;
  logic        frame_done;

  max31855_responder #(
    .CONV_CYCLES (CONV),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .SPI_clk      (SPI_clk),
    .SPI_cs       (SPI_cs),
    .SPI_Data_Out (SPI_Data_Out),
    .tc_temp      (tc_temp),
    .int_temp     (int_temp),
    .fault_in     (fault_in),
    .conv_valid   (conv_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Reference state: frame captured by the last completed conversion
  logic [31:0] exp_frame;
  logic        exp_valid;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame value from the datasheet field rules, built arithmetically
  function automatic logic [31:0] model_frame(input logic [13:0] tc, input logic [11:0] it,
                                              input logic [2:0] f);
    int unsigned v;
    int unsigned tcv;
    int unsigned itv;
    int unsigned fv;
    tcv = tc;
    itv = it;
    fv  = f;
    v   = tcv * 262144 + itv * 16;
`ifdef MAX31855_FAULT_INJECT_EN
    if (fv != 0) v = v + 65536;
    v = v + fv;
`endif
    return 32'(v);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Master read: sample SO at the end of each low half, then pulse SPI_clk
  task automatic spi_read(input int nbits, output logic [63:0] bits, output int dones);
    int d0;
    d0     = done_cnt;
    bits   = '0;
    SPI_cs = 1'b0;
    wait_clks(H);
    for (int i = 0; i < nbits; i++) begin
      bits    = {bits[62:0], SPI_Data_Out};
      SPI_clk = 1'b1;
      wait_clks(H);
      SPI_clk = 1'b0;
      wait_clks(H);
    end
    wait_clks(H);
    dones  = done_cnt - d0;
    SPI_cs = 1'b1;
    wait_clks(8);
  endtask

  task automatic do_read(input string tag, input int nbits);
    logic [63:0] got;
    logic [63:0] exp;
    int          dones;
    spi_read(nbits, got, dones);
    if (nbits <= 32) exp = 64'(exp_frame) >> (32 - nbits);
    else             exp = 64'(exp_frame) << (nbits - 32);
    check({tag, "_data"}, got, exp);
    check({tag, "_done"}, 64'(dones), (nbits >= 32) ? 64'd1 : 64'd0);
    check({tag, "_idle_so"}, 64'(SPI_Data_Out), 64'd0);
    check({tag, "_valid"}, 64'(conv_valid), 64'(exp_valid));
  endtask

  // Present new inputs with SPI_cs high; a long window completes a conversion
  task automatic idle_window(input logic [13:0] tc, input logic [11:0] it,
                             input logic [2:0] f, input bit complete);
    tc_temp  = tc;
    int_temp = it;
    fault_in = f;
    if (complete) begin
      wait_clks(int'(CONV) + 20 + int'($urandom_range(0, 40)));
      exp_frame = model_frame(tc, it, f);
      exp_valid = 1'b1;
    end else begin
      wait_clks(int'($urandom_range(10, CONV - 30)));
    end
  endtask

  initial begin
    int d0;
    reset    = 1'b1;
    SPI_clk  = 1'b0;
    SPI_cs   = 1'b1;
    tc_temp  = 14'h0190;
    int_temp = 12'h190;
    fault_in = 3'b000;
    exp_frame = '0;
    exp_valid = 1'b0;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(5);

    check("rst_so",    64'(SPI_Data_Out), 64'd0);
    check("rst_valid", 64'(conv_valid),   64'd0);
    check("rst_done",  64'(frame_done),   64'd0);

    // Read before any conversion: all-zero frame
    do_read("preconv", 32);

    // Nominal temperatures
    idle_window(14'h0190, 12'h190, 3'b000, 1'b1);
    do_read("nominal", 32);

    // Open-circuit fault flag
    idle_window(14'h0190, 12'h190, 3'b001, 1'b1);
    do_read("fault_oc", 32);

    // Negative temperature keeps its sign bits
    idle_window(14'h3FFC, 12'hFF0, 3'b110, 1'b1);
    do_read("negative", 32);

    // Aborted read followed by a short window keeps the previous frame
    do_read("abort10", 10);
    idle_window(14'($urandom), 12'($urandom), 3'($urandom), 1'b0);
    do_read("kept", 32);

    // Over-clocked frame: trailing bits are zero
    idle_window(14'($urandom), 12'($urandom), 3'($urandom), 1'b1);
    do_read("over40", 40);

    // Randomized windows and read lengths
    for (int i = 0; i < 12; i++) begin
      idle_window(14'($urandom), 12'($urandom), 3'($urandom), 1'($urandom));
      do_read("rand", int'($urandom_range(8, 40)));
    end

    // Reset in the middle of a frame
    idle_window(14'h3FFF, 12'h000, 3'b000, 1'b1);
    d0     = done_cnt;
    SPI_cs = 1'b0;
    wait_clks(H);
    for (int i = 0; i < 12; i++) begin
      SPI_clk = 1'b1;
      wait_clks(H);
      SPI_clk = 1'b0;
      wait_clks(H);
    end
    check("midrst_pre_so", 64'(SPI_Data_Out), 64'd1);
    reset = 1'b1;
    wait_clks(2);
    check("midrst_so",    64'(SPI_Data_Out), 64'd0);
    check("midrst_valid", 64'(conv_valid),   64'd0);
    SPI_cs = 1'b1;
    wait_clks(3);
    reset     = 1'b0;
    exp_frame = '0;
    exp_valid = 1'b0;
    wait_clks(2);
    check("midrst_post_so", 64'(SPI_Data_Out), 64'd0);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    idle_window(14'($urandom), 12'($urandom), 3'($urandom), 1'b1);
    do_read("postrst", 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
